// File: rtl/uart_rx_engine_if.sv
// Core-side port of the UART receive engine: read strobe in, character and status out.
// The engine takes the slave modport; the core (or a bench standing in for it) takes the master modport.
interface uart_rx_engine_if;
    logic       rx_clr;
    logic [7:0] rx_data;
    logic       rxrdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    modport master (output rx_clr, input rx_data, input rxrdy, input perr, input ferr, input ovf);
    modport slave  (input rx_clr, output rx_data, output rxrdy, output perr, output ferr, output ovf);
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes the RX line, frames 7/8 data bits with optional
// parity, and presents the character plus parity/framing/overrun flags to the core.
module uart_rx_engine #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_in,
    input  logic [3:0]      baudm,
    input  logic            bit8,
    input  logic            pen,
    input  logic            ohel,
    uart_rx_engine_if.slave core
);
    // Wide enough for the slowest rate (300 baud).
    localparam int unsigned TW = $clog2(CLK_HZ / 300 + 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Bit time in clocks, rounded to nearest; each branch folds to a constant.
    function automatic logic [TW-1:0] bt_of(input logic [3:0] m);
        logic [TW-1:0] r;
        case (m)
            4'd0:    r = TW'((CLK_HZ + 150) / 300);
            4'd1:    r = TW'((CLK_HZ + 600) / 1200);
            4'd2:    r = TW'((CLK_HZ + 1200) / 2400);
            4'd3:    r = TW'((CLK_HZ + 2400) / 4800);
            4'd4:    r = TW'((CLK_HZ + 4800) / 9600);
            4'd5:    r = TW'((CLK_HZ + 9600) / 19200);
            4'd6:    r = TW'((CLK_HZ + 19200) / 38400);
            4'd7:    r = TW'((CLK_HZ + 28800) / 57600);
            4'd8:    r = TW'((CLK_HZ + 57600) / 115200);
            4'd9:    r = TW'((CLK_HZ + 115200) / 230400);
            4'd10:   r = TW'((CLK_HZ + 230400) / 460800);
            default: r = TW'((CLK_HZ + 460800) / 921600);
        endcase
        return r;
    endfunction

    logic          sync1_q, sync2_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] bt_q, bt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit8_q, bit8_d;
    logic          pen_q, pen_d;
    logic          ohel_q, ohel_d;
    logic          perr_n_q, perr_n_d;
    logic          ferr_n_q, ferr_n_d;
    logic          seen_high_q, seen_high_d;
    logic          done_q, done_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rxrdy_q, rxrdy_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;
    logic          sample_now;
    logic [3:0]    last_bit;

    assign rx_s       = sync2_q;
    assign sample_now = (timer_q == '0);
    assign last_bit   = bit8_q ? 4'd7 : 4'd6;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bt_d        = bt_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        bit8_d      = bit8_q;
        pen_d       = pen_q;
        ohel_d      = ohel_q;
        perr_n_d    = perr_n_q;
        ferr_n_d    = ferr_n_q;
        seen_high_d = seen_high_q;
        done_d      = 1'b0;

        if (state_q != S_IDLE) begin
            timer_d = sample_now ? (bt_q - TW'(1)) : (timer_q - TW'(1));
        end

        case (state_q)
            S_IDLE: begin
                // A held-low line must return high once before a new start is accepted.
                if (rx_s) begin
                    seen_high_d = 1'b1;
                end else if (seen_high_q) begin
                    state_d  = S_START;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    perr_n_d = 1'b0;
                    ferr_n_d = 1'b0;
                    bt_d     = bt_of(baudm);
                    timer_d  = (bt_of(baudm) >> 1) - TW'(1);
                    bit8_d   = bit8;
                    pen_d    = pen;
                    ohel_d   = ohel;
                end
            end
            S_START: begin
                if (sample_now) begin
                    if (rx_s) begin
                        state_d     = S_IDLE;
                        seen_high_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (sample_now) begin
                    shift_d[bitcnt_q[2:0]] = rx_s;
                    bitcnt_d               = bitcnt_q + 4'd1;
                    if (bitcnt_q == last_bit) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (sample_now) begin
                    perr_n_d = (((^shift_q) ^ rx_s) != ohel_q);
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (sample_now) begin
                    ferr_n_d    = ~rx_s;
                    done_d      = 1'b1;
                    seen_high_d = rx_s;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Completion beats a coincident read strobe; the strobe still cancels overrun.
    always_comb begin
        rx_data_d = rx_data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        if (done_q) begin
            rx_data_d = shift_q;
            rxrdy_d   = 1'b1;
            perr_d    = perr_n_q;
            ferr_d    = ferr_n_q;
            ovf_d     = core.rx_clr ? 1'b0 : (ovf_q | rxrdy_q);
        end else if (core.rx_clr) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bt_q        <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            bit8_q      <= 1'b0;
            pen_q       <= 1'b0;
            ohel_q      <= 1'b0;
            perr_n_q    <= 1'b0;
            ferr_n_q    <= 1'b0;
            seen_high_q <= 1'b0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rxrdy_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= rx_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bt_q        <= bt_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            bit8_q      <= bit8_d;
            pen_q       <= pen_d;
            ohel_q      <= ohel_d;
            perr_n_q    <= perr_n_d;
            ferr_n_q    <= ferr_n_d;
            seen_high_q <= seen_high_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            rxrdy_q     <= rxrdy_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign core.rx_data = rx_data_q;
    assign core.rxrdy   = rxrdy_q;
    assign core.perr    = perr_q;
    assign core.ferr    = ferr_q;
    assign core.ovf     = ovf_q;
endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: frames are scheduled as transactions whose completion cycle
// and flags follow from the line protocol; outputs are compared every cycle.
module tb_uart_rx_engine;
    localparam int unsigned CLK = 20_000_000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic [3:0] baudm = 4'd8;
    logic       bit8 = 1'b1;
    logic       pen = 1'b0;
    logic       ohel = 1'b0;

    uart_rx_engine_if core ();

    uart_rx_engine #(.CLK_HZ(CLK)) dut (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx_in),
        .baudm (baudm),
        .bit8  (bit8),
        .pen   (pen),
        .ohel  (ohel),
        .core  (core)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  d;
        logic        pe;
        logic        fe;
    } ev_t;

    ev_t         evq[$];
    ev_t         cur_ev;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned pc = 0;
    int unsigned clr_at = 0;
    int unsigned rise_cyc = 0;
    logic [7:0]  exp_data = 8'h00;
    logic        exp_rdy = 1'b0, exp_pe = 1'b0, exp_fe = 1'b0, exp_ovf = 1'b0;
    logic        clr_prev = 1'b0;
    logic        rdy_last = 1'b0;

    always @(posedge clk) pc <= pc + 1;

    // Nearest-integer clocks per bit for the baud table.
    function automatic int bt_model(input longint hz, input int m);
        longint rates[16] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                              115200, 230400, 460800, 921600, 921600, 921600, 921600, 921600};
        return int'((hz + rates[m] / 2) / rates[m]);
    endfunction

    // Reference state advanced once per clock edge, then compared with the DUT.
    always @(negedge clk) begin
        if (reset) begin
            exp_data = 8'h00; exp_rdy = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0; exp_ovf = 1'b0;
            evq.delete();
            clr_prev = 1'b0;
        end else begin
            if (evq.size() > 0 && evq[0].cyc < pc) begin
                vectors++;
                miscompares++;
                $display("FAIL schedule: frame due at cycle %0d not applied, now %0d", evq[0].cyc, pc);
                cur_ev = evq.pop_front();
            end
            if (evq.size() > 0 && evq[0].cyc == pc) begin
                cur_ev   = evq.pop_front();
                exp_ovf  = clr_prev ? 1'b0 : (exp_ovf | exp_rdy);
                exp_rdy  = 1'b1;
                exp_data = cur_ev.d;
                exp_pe   = cur_ev.pe;
                exp_fe   = cur_ev.fe;
            end else if (clr_prev) begin
                exp_rdy = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0; exp_ovf = 1'b0;
            end
            clr_prev = core.rx_clr;
        end
        vectors++;
        if ({core.rx_data, core.rxrdy, core.perr, core.ferr, core.ovf} !==
            {exp_data, exp_rdy, exp_pe, exp_fe, exp_ovf}) begin
            miscompares++;
            $display("FAIL outputs cyc %0d: got data=%h rdy=%b perr=%b ferr=%b ovf=%b, expected data=%h rdy=%b perr=%b ferr=%b ovf=%b",
                     pc, core.rx_data, core.rxrdy, core.perr, core.ferr, core.ovf,
                     exp_data, exp_rdy, exp_pe, exp_fe, exp_ovf);
        end
        if (core.rxrdy === 1'b1 && rdy_last !== 1'b1) rise_cyc = pc;
        rdy_last = core.rxrdy;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick(input logic v);
        rx_in       = v;
        core.rx_clr = (clr_at != 0) && (pc + 1 == clr_at);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic do_clr();
        clr_at = pc + 1;
        tick(1'b1);
        tick(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic bad_par,
                              input logic mid_chg, input logic clr_at_done);
        int         bt, nd;
        logic [3:0] m0;
        logic       b8, pe, od, pbit;
        logic [7:0] dd;
        ev_t        e;
        m0 = baudm; b8 = bit8; pe = pen; od = ohel;
        bt = bt_model(longint'(CLK), int'(m0));
        nd = b8 ? 8 : 7;
        dd = d;
        if (!b8) dd[7] = 1'b0;
        pbit  = (^dd) ^ od ^ bad_par;
        e.cyc = pc + 32'(4 + bt / 2 + (nd + int'(pe) + 1) * bt);
        e.d   = dd;
        e.pe  = pe & bad_par;
        e.fe  = ~stop_v;
        evq.push_back(e);
        if (clr_at_done) clr_at = e.cyc;
        $display("frame data=%h bits=%0d pen=%b odd=%b bt=%0d stop=%b badpar=%b due=%0d",
                 dd, nd, pe, od, bt, stop_v, bad_par, e.cyc);
        repeat (bt) tick(1'b0);
        for (int i = 0; i < nd; i++) begin
            if (mid_chg && i == 3) baudm = ~m0;
            repeat (bt) tick(dd[i]);
        end
        if (pe) repeat (bt) tick(pbit);
        repeat (bt) tick(stop_v);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned p0;
        int          k;
        core.rx_clr = 1'b0;
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        check("reset rx_data", 32'(core.rx_data), 32'h0);
        check("reset flags", {28'h0, core.rxrdy, core.perr, core.ferr, core.ovf}, 32'h0);
        check("model bt 100MHz/115200", 32'(bt_model(64'd100_000_000, 8)), 32'd868);
        check("model bt 100MHz/9600", 32'(bt_model(64'd100_000_000, 4)), 32'd10417);
        check("model bt 20MHz/115200", 32'(bt_model(longint'(CLK), 8)), 32'd174);
        idle(10);

        // 8N1 0xA5 with exact latency from the falling start edge
        baudm = 4'd8; bit8 = 1'b1; pen = 1'b0; ohel = 1'b0;
        p0 = pc;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("8N1 data", 32'(core.rx_data), 32'hA5);
        check("8N1 latency", rise_cyc - p0, 32'd1657);
        check("8N1 flags", {28'h0, core.rxrdy, core.perr, core.ferr, core.ovf}, 32'b1000);
        do_clr();

        // 7E1: wrong then correct parity
        bit8 = 1'b0; pen = 1'b1; ohel = 1'b0;
        send_frame(8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("7E1 bad data", 32'(core.rx_data), 32'h41);
        check("7E1 bad perr", 32'(core.perr), 32'h1);
        do_clr();
        send_frame(8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("7E1 good flags", {28'h0, core.rxrdy, core.perr, core.ferr, core.ovf}, 32'b1000);

        // 8O1 with stop bit low
        do_clr();
        bit8 = 1'b1; pen = 1'b1; ohel = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("8O1 ferr flags", {28'h0, core.rxrdy, core.perr, core.ferr, core.ovf}, 32'b1010);
        do_clr();
        check("8O1 cleared", {28'h0, core.rxrdy, core.perr, core.ferr, core.ovf}, 32'b0000);

        // overrun, then a read strobe landing on the completion cycle
        pen = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        check("overrun data", 32'(core.rx_data), 32'h22);
        check("overrun ovf", 32'(core.ovf), 32'h1);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(10);
        check("clr at completion", {28'h0, core.rxrdy, core.perr, core.ferr, core.ovf}, 32'b1000);
        do_clr();

        // short low glitch is a false start
        repeat (80) tick(1'b0);
        idle(200);
        check("glitch rxrdy", 32'(core.rxrdy), 32'h0);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        do_clr();

        // reset in the middle of the data bits discards the frame
        repeat (174) tick(1'b0);
        repeat (3 * 174) tick(1'b1);
        reset = 1'b1;
        idle(4);
        check("reset mid-frame", {20'h0, core.rx_data, core.rxrdy, core.perr, core.ferr, core.ovf}, 32'h0);
        reset = 1'b0;
        idle(10);
        baudm = 4'd8;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("post-reset data", 32'(core.rx_data), 32'h5A);
        do_clr();

        // randomized frames at the faster rates
        for (int n = 0; n < 30; n++) begin
            baudm = 4'($urandom_range(9, 15));
            bit8  = 1'($urandom);
            pen   = 1'($urandom);
            ohel  = 1'($urandom);
            k     = int'($urandom_range(0, 3));
            if (k == 1) clr_at = pc + $urandom_range(1, 600);
            send_frame(8'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), (k == 2));
            idle(int'($urandom_range(3, 40)));
        end
        idle(50);
        check("all frames delivered", 32'(evq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
